// File: rtl/xfcp_frame_buffer_pkg.sv
// Shared types for the XFCP store-and-forward frame buffer.
package xfcp_frame_buffer_pkg;

   localparam int DATA_WIDTH = 8;

   // One stored RAM word: frame byte plus its end-of-frame and bad-frame flags.
   typedef struct packed {
      logic                  tuser;
      logic                  tlast;
      logic [DATA_WIDTH-1:0] tdata;
   } word_t;

   localparam int WORD_WIDTH = $bits(word_t);

   // Input-side frame tracking.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_DROP   = 2'd2
   } in_state_t;

endpackage

// File: rtl/xfcp_frame_buffer_if.sv
// Byte-wide XFCP stream with valid/ready handshake and frame markers.
interface xfcp_frame_buffer_if;
   import xfcp_frame_buffer_pkg::*;

   logic [DATA_WIDTH-1:0] tdata;
   logic                  tvalid;
   logic                  tready;
   logic                  tlast;
   logic                  tuser;

   modport master (output tdata, output tvalid, input tready, output tlast, output tuser);
   modport slave  (input tdata, input tvalid, output tready, input tlast, input tuser);

endinterface

// File: rtl/xfcp_frame_buffer_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
module xfcp_frame_buffer_ram #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 2048
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_wr_en,
   input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
   input  logic [WIDTH-1:0]         i_wr_data,
   input  logic                     i_rd_en,
   input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
   output logic [WIDTH-1:0]         o_rd_data
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [WIDTH-1:0] r_rd_data;

   // Write port: storage array carries no reset so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (i_wr_en) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
   end

   // Read port: output register holds its value until the next read, cleared by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd_data <= '0;
      end else if (i_rd_en) begin
         r_rd_data <= r_mem[i_rd_addr];
      end
   end

   assign o_rd_data = r_rd_data;

endmodule

// File: rtl/xfcp_frame_buffer.sv
// Store-and-forward XFCP frame buffer: a frame becomes readable only after its
// last byte is accepted and it is known good; bad or overflowing frames vanish.
module xfcp_frame_buffer
   import xfcp_frame_buffer_pkg::*;
#(
   parameter int DEPTH          = 2048,
   parameter bit DROP_BAD_FRAME = 1'b1
) (
   input  logic                clk,
   input  logic                rst,
   xfcp_frame_buffer_if.slave  xfcp_in,
   xfcp_frame_buffer_if.master xfcp_out,
   output logic                status_good_frame,
   output logic                status_bad_frame,
   output logic                status_overflow
);

   localparam int ADDR_WIDTH = $clog2(DEPTH);
   localparam int PTR_WIDTH  = ADDR_WIDTH + 1;
   localparam logic [PTR_WIDTH-1:0] PTR_ONE   = PTR_WIDTH'(1);
   localparam logic [PTR_WIDTH-1:0] PTR_DEPTH = PTR_WIDTH'(DEPTH);

   in_state_t              r_state, w_state_next;
   logic [PTR_WIDTH-1:0]   r_wr_ptr, r_wr_commit, r_rd_ptr;
   logic [PTR_WIDTH-1:0]   w_wr_ptr_next, w_wr_commit_next;
   logic                   w_wr_en, w_good, w_bad, w_ovf;
   logic                   r_good, r_bad, r_ovf;
   logic                   w_full, w_empty, w_rd_en, w_bad_tail;
   logic                   r_out_valid;
   word_t                  w_wr_word, w_rd_word;

   // The input never stalls; overflow is resolved by dropping the frame.
   assign xfcp_in.tready = 1'b1;

   // Full counts against rd_ptr: uncommitted bytes still occupy space.
   assign w_full     = (r_wr_ptr - r_rd_ptr) == PTR_DEPTH;
   assign w_empty    = (r_rd_ptr == r_wr_commit);
   assign w_bad_tail = xfcp_in.tlast && xfcp_in.tuser && DROP_BAD_FRAME;

   assign w_wr_word.tuser = xfcp_in.tuser;
   assign w_wr_word.tlast = xfcp_in.tlast;
   assign w_wr_word.tdata = xfcp_in.tdata;

   // Input FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Input FSM next state: a full buffer diverts the rest of the frame to DROP.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE, ST_ACTIVE: begin
            if (xfcp_in.tvalid) begin
               if (xfcp_in.tlast) begin
                  w_state_next = ST_IDLE;
               end else if (w_full) begin
                  w_state_next = ST_DROP;
               end else begin
                  w_state_next = ST_ACTIVE;
               end
            end
         end
         ST_DROP: begin
            if (xfcp_in.tvalid && xfcp_in.tlast) begin
               w_state_next = ST_IDLE;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   // Input FSM outputs: RAM write, pointer rewind/commit and status events.
   always_comb begin
      w_wr_en          = 1'b0;
      w_wr_ptr_next    = r_wr_ptr;
      w_wr_commit_next = r_wr_commit;
      w_good           = 1'b0;
      w_bad            = 1'b0;
      w_ovf            = 1'b0;
      if (r_state != ST_DROP && xfcp_in.tvalid) begin
         if (w_full) begin
            w_wr_ptr_next = r_wr_commit;
            w_ovf         = 1'b1;
         end else begin
            w_wr_en = 1'b1;
            if (w_bad_tail) begin
               w_wr_ptr_next = r_wr_commit;
               w_bad         = 1'b1;
            end else if (xfcp_in.tlast) begin
               w_wr_ptr_next    = r_wr_ptr + PTR_ONE;
               w_wr_commit_next = r_wr_ptr + PTR_ONE;
               w_good           = 1'b1;
            end else begin
               w_wr_ptr_next = r_wr_ptr + PTR_ONE;
            end
         end
      end
   end

   // Write-side pointers and registered status pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr    <= '0;
         r_wr_commit <= '0;
         r_good      <= 1'b0;
         r_bad       <= 1'b0;
         r_ovf       <= 1'b0;
      end else begin
         r_wr_ptr    <= w_wr_ptr_next;
         r_wr_commit <= w_wr_commit_next;
         r_good      <= w_good;
         r_bad       <= w_bad;
         r_ovf       <= w_ovf;
      end
   end

   assign status_good_frame = r_good;
   assign status_bad_frame  = r_bad;
   assign status_overflow   = r_ovf;

   // The RAM read register doubles as the output data register.
   assign w_rd_en = (!r_out_valid || xfcp_out.tready) && !w_empty;

   // Read pointer and output valid flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd_ptr    <= '0;
         r_out_valid <= 1'b0;
      end else begin
         if (w_rd_en) begin
            r_rd_ptr <= r_rd_ptr + PTR_ONE;
         end
         if (w_rd_en) begin
            r_out_valid <= 1'b1;
         end else if (xfcp_out.tready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   xfcp_frame_buffer_ram #(
      .WIDTH (WORD_WIDTH),
      .DEPTH (DEPTH)
   ) u_ram (
      .clk       (clk),
      .rst       (rst),
      .i_wr_en   (w_wr_en),
      .i_wr_addr (r_wr_ptr[ADDR_WIDTH-1:0]),
      .i_wr_data (w_wr_word),
      .i_rd_en   (w_rd_en),
      .i_rd_addr (r_rd_ptr[ADDR_WIDTH-1:0]),
      .o_rd_data (w_rd_word)
   );

   assign xfcp_out.tvalid = r_out_valid;
   assign xfcp_out.tdata  = w_rd_word.tdata;
   assign xfcp_out.tlast  = w_rd_word.tlast;
   assign xfcp_out.tuser  = DROP_BAD_FRAME ? 1'b0 : w_rd_word.tuser;

endmodule

// File: tb/tb_xfcp_frame_buffer.sv
// Scoreboard bench for xfcp_frame_buffer (DEPTH=16, bad frames dropped).
module tb_xfcp_frame_buffer;

   localparam int DEPTH = 16;

   typedef logic [7:0] bq_t[$];

   logic clk = 1'b0;
   logic rst;
   logic s_good, s_bad, s_ovf;

   always #5 clk = ~clk;

   xfcp_frame_buffer_if xin();
   xfcp_frame_buffer_if xout();

   xfcp_frame_buffer #(
      .DEPTH          (DEPTH),
      .DROP_BAD_FRAME (1'b1)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .xfcp_in           (xin),
      .xfcp_out          (xout),
      .status_good_frame (s_good),
      .status_bad_frame  (s_bad),
      .status_overflow   (s_ovf)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int n_good = 0, n_bad = 0, n_ovf = 0;
   int rise_cyc = 0;
   int last_cyc = 0;
   logic prev_valid = 1'b0;
   logic [9:0] sb[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end else begin
         $display("ok   %s observed=%0h", tag, obs);
      end
   endtask

   // Monitor: counts status pulses, tracks valid rise, compares output handshakes.
   always @(negedge clk) begin
      if (rst === 1'b0) begin
         if (s_good === 1'b1) n_good++;
         if (s_bad === 1'b1) n_bad++;
         if (s_ovf === 1'b1) n_ovf++;
         if (xout.tvalid === 1'b1 && !prev_valid) rise_cyc = cyc;
         if (xout.tvalid === 1'b1 && xout.tready === 1'b1) begin
            if (sb.size() == 0) begin
               check("out_unexpected", 32'({xout.tuser, xout.tlast, xout.tdata}), 32'hFFFF_FFFF);
            end else begin
               check("out_byte", 32'({xout.tuser, xout.tlast, xout.tdata}), 32'(sb.pop_front()));
            end
         end
      end
      prev_valid = (xout.tvalid === 1'b1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] d, input logic last, input logic user);
      xin.tdata  = d;
      xin.tvalid = 1'b1;
      xin.tlast  = last;
      xin.tuser  = user;
      if (last) last_cyc = cyc;
      tick();
      xin.tvalid = 1'b0;
      xin.tlast  = 1'b0;
      xin.tuser  = 1'b0;
   endtask

   task automatic send_frame(input bq_t fr, input logic user, input bit expect_out);
      if (expect_out) begin
         foreach (fr[i]) sb.push_back({1'b0, (i == fr.size() - 1), fr[i]});
      end
      foreach (fr[i]) send_byte(fr[i], (i == fr.size() - 1), user);
   endtask

   task automatic wait_drain();
      int n = 0;
      while ((sb.size() != 0 || xout.tvalid === 1'b1) && n < 400) begin
         tick();
         n++;
      end
      repeat (3) tick();
      check("drain", 32'(sb.size()), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bq_t f;
      int g0, b0, o0;
      bit done;

      xin.tdata = 8'h00; xin.tvalid = 1'b0; xin.tlast = 1'b0; xin.tuser = 1'b0;
      xout.tready = 1'b1;
      rst = 1'b1;
      repeat (3) tick();
      check("rst_tvalid", 32'(xout.tvalid), 32'd0);
      check("rst_tdata",  32'(xout.tdata), 32'd0);
      check("rst_tlast",  32'(xout.tlast), 32'd0);
      check("rst_status", 32'({s_good, s_bad, s_ovf}), 32'd0);
      check("in_tready",  32'(xin.tready), 32'd1);
      rst = 1'b0;
      tick();

      // Good 16-byte frame with latency measurement.
      g0 = n_good; b0 = n_bad; o0 = n_ovf;
      f = {};
      for (int i = 0; i < 16; i++) f.push_back(8'(i));
      send_frame(f, 1'b0, 1'b1);
      wait_drain();
      check("good_cnt", 32'(n_good - g0), 32'd1);
      check("latency", 32'(rise_cyc - last_cyc), 32'd2);
      check("good_no_ovf", 32'(n_ovf - o0), 32'd0);

      // Bad frame dropped, following good frame forwarded.
      g0 = n_good; b0 = n_bad; o0 = n_ovf;
      f = {};
      for (int i = 0; i < 8; i++) f.push_back(8'(8'h50 + i));
      send_frame(f, 1'b1, 1'b0);
      f = {8'hAA, 8'hBB};
      send_frame(f, 1'b0, 1'b1);
      wait_drain();
      check("bad_cnt", 32'(n_bad - b0), 32'd1);
      check("bad_good_cnt", 32'(n_good - g0), 32'd1);

      // Overflow of a 20-byte frame while output is stalled.
      xout.tready = 1'b0;
      g0 = n_good; b0 = n_bad; o0 = n_ovf;
      f = {};
      for (int i = 0; i < 20; i++) f.push_back(8'(8'h60 + i));
      send_frame(f, 1'b0, 1'b0);
      repeat (3) tick();
      check("ovf_cnt", 32'(n_ovf - o0), 32'd1);
      check("ovf_no_valid", 32'(xout.tvalid), 32'd0);
      f = {8'hC0, 8'hC1, 8'hC2};
      send_frame(f, 1'b0, 1'b1);
      repeat (4) tick();
      check("hold_valid", 32'(xout.tvalid), 32'd1);
      check("hold_data", 32'(xout.tdata), 32'hC0);
      repeat (3) tick();
      check("hold_data_stable", 32'(xout.tdata), 32'hC0);
      xout.tready = 1'b1;
      wait_drain();
      check("ovf_good_cnt", 32'(n_good - g0), 32'd1);
      check("ovf_once", 32'(n_ovf - o0), 32'd1);

      // Exact-capacity frame commits without overflow.
      xout.tready = 1'b0;
      g0 = n_good; o0 = n_ovf;
      f = {};
      for (int i = 0; i < DEPTH; i++) f.push_back(8'(8'h80 + i));
      send_frame(f, 1'b0, 1'b1);
      repeat (4) tick();
      check("cap_good_cnt", 32'(n_good - g0), 32'd1);
      check("cap_no_ovf", 32'(n_ovf - o0), 32'd0);
      xout.tready = 1'b1;
      wait_drain();

      // Backpressure and pointer wrap: 10 frames of 7 bytes.
      g0 = n_good; b0 = n_bad; o0 = n_ovf;
      done = 1'b0;
      fork
         begin
            for (int fi = 0; fi < 10; fi++) begin
               bq_t fw;
               fw = {};
               for (int i = 0; i < 7; i++) fw.push_back(8'($urandom_range(0, 255)));
               send_frame(fw, 1'b0, 1'b1);
               repeat (5) tick();
            end
            done = 1'b1;
         end
         begin
            while (!done) begin
               xout.tready = 1'b1; tick();
               xout.tready = 1'b0; tick();
               xout.tready = 1'b1; tick();
            end
         end
      join
      xout.tready = 1'b1;
      wait_drain();
      check("wrap_good_cnt", 32'(n_good - g0), 32'd10);
      check("wrap_no_ovf", 32'(n_ovf - o0), 32'd0);
      check("wrap_no_bad", 32'(n_bad - b0), 32'd0);

      // Reset mid-stream discards buffered and partial data.
      xout.tready = 1'b0;
      f = {8'h11, 8'h22, 8'h33};
      send_frame(f, 1'b0, 1'b0);
      repeat (3) tick();
      check("pre_rst_valid", 32'(xout.tvalid), 32'd1);
      send_byte(8'h44, 1'b0, 1'b0);
      send_byte(8'h55, 1'b0, 1'b0);
      rst = 1'b1;
      tick();
      tick();
      check("mid_rst_tvalid", 32'(xout.tvalid), 32'd0);
      check("mid_rst_status", 32'({s_good, s_bad, s_ovf}), 32'd0);
      rst = 1'b0;
      xout.tready = 1'b1;
      tick();
      g0 = n_good;
      f = {8'h01, 8'h02, 8'h03, 8'h04};
      send_frame(f, 1'b0, 1'b1);
      wait_drain();
      check("post_rst_good_cnt", 32'(n_good - g0), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
